// File: rtl/ibex_shadow_stack_ctrl_if.sv
// Event and shadow-stack signal bundle for ibex_shadow_stack_ctrl.
// The slave modport is the controller; the master modport is the core/stack side.
interface ibex_shadow_stack_ctrl_if;
    logic        en_i;
    logic        call_valid_i;
    logic [31:0] call_addr_i;
    logic        ret_valid_i;
    logic [31:0] ret_addr_i;
    logic        evt_ready_o;
    logic        ss_push_o;
    logic [31:0] ss_push_data_o;
    logic        ss_pop_o;
    logic [31:0] ss_pop_data_o;
    logic        ss_error_i;
    logic        alarm_o;
    logic [1:0]  alarm_cause_o;
    logic        alarm_clr_i;
    logic        busy_o;

    modport slave (
        input  en_i, call_valid_i, call_addr_i, ret_valid_i, ret_addr_i,
               ss_error_i, alarm_clr_i,
        output evt_ready_o, ss_push_o, ss_push_data_o, ss_pop_o, ss_pop_data_o,
               alarm_o, alarm_cause_o, busy_o
    );

    modport master (
        output en_i, call_valid_i, call_addr_i, ret_valid_i, ret_addr_i,
               ss_error_i, alarm_clr_i,
        input  evt_ready_o, ss_push_o, ss_push_data_o, ss_pop_o, ss_pop_data_o,
               alarm_o, alarm_cause_o, busy_o
    );
endinterface

// File: rtl/ibex_shadow_stack_ctrl.sv
// Sequencer between retire stage and shadow stack: queues call/return events, issues
// push/pop strobes and classifies stack errors. Define IBEX_SS_CTRL_LOCK_EN to make ALARM reset-only.
module ibex_shadow_stack_ctrl #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned STACK_AW    = 8
) (
    input logic                     clk_i,
    input logic                     rst_i,
    ibex_shadow_stack_ctrl_if.slave bus
);

    localparam int unsigned QAW = $clog2(QUEUE_DEPTH);
    localparam logic [STACK_AW-1:0] DEPTH_MAX = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ALARM} state_e;
    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_OVF  = 2'd1,
        CAUSE_UNF  = 2'd2,
        CAUSE_MIS  = 2'd3
    } cause_e;

    state_e              state_q, state_d;
    cause_e              cause_q, pend_cause_q, pred_cause;
    logic                pend_inc_q;
    logic [STACK_AW-1:0] depth_q;

    logic [32:0]         fifo_q [QUEUE_DEPTH];
    logic [QAW:0]        wr_ptr_q, rd_ptr_q, count, free;
    logic [QAW-1:0]      wr_idx0, wr_idx1;
    logic                fifo_empty, discard, accept, push_call, push_ret;
    logic                head_is_ret, clr_eff;
    logic [31:0]         head_addr;

`ifdef IBEX_SS_CTRL_LOCK_EN
    logic unused_clr;
    assign unused_clr = bus.alarm_clr_i;
    assign clr_eff    = 1'b0;
`else
    assign clr_eff    = bus.alarm_clr_i;
`endif

    assign count      = wr_ptr_q - rd_ptr_q;
    assign free       = (QAW+1)'(QUEUE_DEPTH) - count;
    assign fifo_empty = (count == '0);
    assign discard    = !bus.en_i || (state_q == ALARM);
    assign accept     = !discard && (free >= (QAW+1)'(2));
    assign push_call  = accept && bus.call_valid_i;
    assign push_ret   = accept && bus.ret_valid_i;
    assign wr_idx0    = wr_ptr_q[QAW-1:0];
    assign wr_idx1    = wr_idx0 + QAW'(1);

    assign head_is_ret = fifo_q[rd_ptr_q[QAW-1:0]][32];
    assign head_addr   = fifo_q[rd_ptr_q[QAW-1:0]][31:0];

    // Call takes the lower slot so it is issued before a same-cycle return.
    always_ff @(posedge clk_i) begin
        if (push_call) fifo_q[wr_idx0] <= {1'b0, bus.call_addr_i};
        if (push_ret)  fifo_q[push_call ? wr_idx1 : wr_idx0] <= {1'b1, bus.ret_addr_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + (QAW+1)'(push_call) + (QAW+1)'(push_ret);
            if (state_q == ALARM)      rd_ptr_q <= wr_ptr_q;
            else if (state_q == ISSUE) rd_ptr_q <= rd_ptr_q + (QAW+1)'(1);
        end
    end

    always_comb begin
        pred_cause = CAUSE_MIS;
        if (head_is_ret && (depth_q == '0))        pred_cause = CAUSE_UNF;
        if (!head_is_ret && (depth_q == DEPTH_MAX)) pred_cause = CAUSE_OVF;
    end

    // Pops adjust the mirror at issue time (the stack pops even on mismatch);
    // pushes only count once the stack has accepted them without error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            depth_q      <= '0;
            pend_cause_q <= CAUSE_NONE;
            pend_inc_q   <= 1'b0;
            cause_q      <= CAUSE_NONE;
        end else begin
            if (state_q == ISSUE) begin
                pend_cause_q <= pred_cause;
                pend_inc_q   <= !head_is_ret && (depth_q != DEPTH_MAX);
                if (head_is_ret && (depth_q != '0)) depth_q <= depth_q - 1'b1;
            end
            if ((state_q == WAIT) && pend_inc_q && !bus.ss_error_i) depth_q <= depth_q + 1'b1;
            if ((state_q == WAIT) && bus.ss_error_i && !clr_eff)   cause_q <= pend_cause_q;
            if ((state_q == ALARM) && clr_eff)                      cause_q <= CAUSE_NONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // WAIT goes straight to ISSUE when more work is queued to sustain one event per two cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!fifo_empty) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.ss_error_i) state_d = clr_eff ? IDLE : ALARM;
                else                state_d = fifo_empty ? IDLE : ISSUE;
            end
            ALARM: if (clr_eff) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.ss_push_o      = (state_q == ISSUE) && !head_is_ret;
    assign bus.ss_pop_o       = (state_q == ISSUE) && head_is_ret;
    assign bus.ss_push_data_o = bus.ss_push_o ? head_addr : '0;
    assign bus.ss_pop_data_o  = bus.ss_pop_o ? head_addr : '0;
    assign bus.evt_ready_o    = discard || (free >= (QAW+1)'(2));
    assign bus.alarm_o        = (state_q == ALARM);
    assign bus.alarm_cause_o  = cause_q;
    assign bus.busy_o         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_ibex_shadow_stack_ctrl.sv
// Self-checking bench for ibex_shadow_stack_ctrl: directed scenarios then random traffic,
// checked against an event-queue plus shadow-stack reference model.
module tb_ibex_shadow_stack_ctrl;
    localparam int unsigned QD  = 4;
    localparam int unsigned SAW = 2;
    localparam int          CAP = (1 << SAW) - 1;
`ifdef IBEX_SS_CTRL_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ibex_shadow_stack_ctrl_if bus ();

    ibex_shadow_stack_ctrl #(.QUEUE_DEPTH(QD), .STACK_AW(SAW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        bit          is_ret;
        logic [31:0] addr;
    } evt_t;

    int          n_checks;
    int          n_errors;
    evt_t        exp_q[$];
    logic [31:0] stk[$];
    bit          alarm_m, wait_m, exp_strobe, err_pend, last_accept, saw_not_ready;
    logic [1:0]  cause_m, cause_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        stk.delete();
        alarm_m    = 1'b0;
        wait_m     = 1'b0;
        exp_strobe = 1'b0;
        err_pend   = 1'b0;
        cause_m    = 2'd0;
        cause_pend = 2'd0;
    endtask

    // One clock cycle: check outputs at the negedge, drive inputs, advance the model at the posedge.
    task automatic tick(input bit cv, input logic [31:0] ca, input bit rv, input logic [31:0] ra,
                        input bit en, input bit clr, input bit do_rst);
        bit          is_push, is_pop, strobe, err, rdy_m, nxt_strobe;
        int          free_m;
        logic [31:0] top;
        evt_t        e;
        @(negedge clk);
        is_push = bus.ss_push_o;
        is_pop  = bus.ss_pop_o;
        strobe  = is_push | is_pop;
        chk("strobe_timing", 32'(strobe), 32'(exp_strobe));
        chk("strobe_exclusive", 32'(is_push & is_pop), 32'd0);
        chk("alarm", 32'(bus.alarm_o), 32'(alarm_m));
        chk("alarm_cause", 32'(bus.alarm_cause_o), 32'(cause_m));
        chk("busy", 32'(bus.busy_o), 32'(exp_q.size() != 0 || alarm_m || wait_m));
        err = 1'b0;
        if (strobe && exp_q.size() != 0) begin
            e = exp_q[0];
            chk("strobe_kind", 32'(is_pop), 32'(e.is_ret));
            chk("strobe_data", is_push ? bus.ss_push_data_o : bus.ss_pop_data_o, e.addr);
            if (is_push) begin
                if (stk.size() >= CAP) begin
                    err = 1'b1;
                    cause_pend = 2'd1;
                end else begin
                    stk.push_back(bus.ss_push_data_o);
                end
            end else if (stk.size() == 0) begin
                err = 1'b1;
                cause_pend = 2'd2;
            end else begin
                top = stk.pop_back();
                if (top != bus.ss_pop_data_o) begin
                    err = 1'b1;
                    cause_pend = 2'd3;
                end
            end
        end
        nxt_strobe = (exp_q.size() != 0) && !strobe && !alarm_m && !(wait_m && bus.ss_error_i);

        bus.call_valid_i = cv;
        bus.call_addr_i  = ca;
        bus.ret_valid_i  = rv;
        bus.ret_addr_i   = ra;
        bus.en_i         = en;
        bus.alarm_clr_i  = clr;
        rst              = do_rst;
        #1;
        free_m = int'(QD) - exp_q.size();
        rdy_m  = (!en || alarm_m) ? 1'b1 : (free_m >= 2);
        chk("evt_ready", 32'(bus.evt_ready_o), 32'(rdy_m));
        if (!bus.evt_ready_o) saw_not_ready = 1'b1;
        if (strobe && exp_q.size() != 0) void'(exp_q.pop_front());
        last_accept = rdy_m && en && !alarm_m;

        @(posedge clk);
        if (do_rst) begin
            model_reset();
        end else begin
            if (alarm_m) begin
                exp_q.delete();
                if (clr && !LOCK) begin
                    alarm_m = 1'b0;
                    cause_m = 2'd0;
                end
            end else begin
                if (last_accept && cv) begin
                    e.is_ret = 1'b0;
                    e.addr   = ca;
                    exp_q.push_back(e);
                end
                if (last_accept && rv) begin
                    e.is_ret = 1'b1;
                    e.addr   = ra;
                    exp_q.push_back(e);
                end
                if (wait_m && bus.ss_error_i && !(clr && !LOCK)) begin
                    alarm_m = 1'b1;
                    cause_m = cause_pend;
                end
            end
            wait_m     = strobe;
            exp_strobe = nxt_strobe;
            err_pend   = err;
        end
        #1;
        bus.ss_error_i = err_pend;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic check_reset_vals();
        chk("rst_push", 32'(bus.ss_push_o), 32'd0);
        chk("rst_pop", 32'(bus.ss_pop_o), 32'd0);
        chk("rst_push_data", bus.ss_push_data_o, 32'd0);
        chk("rst_pop_data", bus.ss_pop_data_o, 32'd0);
        chk("rst_alarm", 32'(bus.alarm_o), 32'd0);
        chk("rst_cause", 32'(bus.alarm_cause_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_ready", 32'(bus.evt_ready_o), 32'd1);
    endtask

    task automatic send_call(input logic [31:0] addr);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            tick(1'b1, addr, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            acc = last_accept;
        end
        chk("bp_call_accepted", 32'(acc), 32'd1);
    endtask

    initial begin
        bit          cv, rv, en, clr, r;
        logic [31:0] ca, ra;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.en_i = 1'b1;
        bus.call_valid_i = 1'b0;
        bus.call_addr_i = '0;
        bus.ret_valid_i = 1'b0;
        bus.ret_addr_i = '0;
        bus.ss_error_i = 1'b0;
        bus.alarm_clr_i = 1'b0;
        model_reset();

        do_reset();
        check_reset_vals();

        // Call then matching return; a further return must then underflow (depth back at 0).
        tick(1'b1, 32'h0000_1004, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(3);
        tick(1'b0, 32'd0, 1'b1, 32'h0000_1004, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("callret_no_alarm", 32'(bus.alarm_o), 32'd0);
        tick(1'b0, 32'd0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("underflow_alarm", 32'(bus.alarm_o), 32'd1);
        chk("underflow_cause", 32'(bus.alarm_cause_o), 32'd2);

        // Mismatch and clear.
        do_reset();
        tick(1'b1, 32'h0000_2000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(3);
        tick(1'b0, 32'd0, 1'b1, 32'h0000_2008, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("mismatch_alarm", 32'(bus.alarm_o), 32'd1);
        chk("mismatch_cause", 32'(bus.alarm_cause_o), 32'd3);
        tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("clr_alarm", 32'(bus.alarm_o), LOCK ? 32'd1 : 32'd0);
        chk("clr_busy", 32'(bus.busy_o), LOCK ? 32'd1 : 32'd0);

        // Overflow with a 3-entry stack, then discarded traffic during ALARM.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 32'h0000_4000 + 32'(4 * i), 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            idle(1);
        end
        idle(3);
        chk("overflow_alarm", 32'(bus.alarm_o), 32'd1);
        chk("overflow_cause", 32'(bus.alarm_cause_o), 32'd1);
        tick(1'b1, 32'h0000_5000, 1'b1, 32'h0000_5000, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("alarm_discard_ready", 32'(bus.evt_ready_o), 32'd1);
`ifndef IBEX_SS_CTRL_LOCK_EN
        tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 2; i >= 0; i--) begin
            tick(1'b0, 32'd0, 1'b1, 32'h0000_4000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            idle(1);
        end
        idle(3);
        chk("depth3_pops_ok", 32'(bus.alarm_o), 32'd0);
        tick(1'b0, 32'd0, 1'b1, 32'h0000_4000, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("depth3_then_underflow", 32'(bus.alarm_cause_o), 32'd2);
`endif

        // Back-pressure: four calls presented back to back.
        do_reset();
        saw_not_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_call(32'h0000_6000 + 32'(4 * i));
        idle(10);
        chk("bp_ready_dropped", 32'(saw_not_ready), 32'd1);

        // Reset while waiting for the stack's error flag.
        do_reset();
        tick(1'b1, 32'h0000_7000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        do_reset();
        check_reset_vals();

        // Random traffic with a small address pool so matches and mismatches both occur.
        for (int n = 0; n < 3000; n++) begin
            cv  = ($urandom_range(0, 2) == 0);
            rv  = ($urandom_range(0, 2) == 0);
            ca  = 32'h0000_1000 + 32'(4 * $urandom_range(0, 1));
            ra  = 32'h0000_1000 + 32'(4 * $urandom_range(0, 1));
            en  = ($urandom_range(0, 15) != 0);
            clr = alarm_m ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            r   = ($urandom_range(0, 299) == 0);
            tick(cv, ca, rv, ra, en, clr, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
